// File: rtl/npu_ctrl_pkg.sv
// Shared types for the window/padding control stage: FSM states, tap count,
// mask type and the tap-index -> (dr, dc) offset lookup.
package npu_ctrl_pkg;

  localparam int TAPS = 9;

  typedef logic [TAPS-1:0] mask_t;
  typedef logic signed [1:0] offs_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Tap 8 is top-left (-1,-1), tap 0 is bottom-right (+1,+1).
  function automatic offs_t tap_dr(input int t);
    return offs_t'((8 - t) / 3 - 1);
  endfunction

  function automatic offs_t tap_dc(input int t);
    return offs_t'((8 - t) % 3 - 1);
  endfunction

endpackage

// File: rtl/pad_mask_gen.sv
// Combinational 3x3 SAME-padding mask: bit t is set when tap t of the window
// centred at (row, col) lies inside the IMG_W x IMG_H map.
module pad_mask_gen
  import npu_ctrl_pkg::*;
#(
  parameter int IMG_W = 80,
  parameter int IMG_H = 8,
  parameter int COL_W = 7,
  parameter int ROW_W = 3
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output mask_t            mask
);

  localparam logic signed [ROW_W:0] ROW_MAX = (ROW_W+1)'(IMG_H - 1);
  localparam logic signed [COL_W:0] COL_MAX = (COL_W+1)'(IMG_W - 1);

  // One extra bit makes row-1 at row 0 negative instead of aliasing high;
  // a +1 overflow at the counter maximum also lands negative, i.e. outside.
  always_comb begin
    logic signed [ROW_W:0] rr;
    logic signed [COL_W:0] cc;
    mask = '0;
    rr   = '0;
    cc   = '0;
    for (int t = 0; t < TAPS; t++) begin
      rr = $signed({1'b0, row}) + (ROW_W+1)'(tap_dr(t));
      cc = $signed({1'b0, col}) + (COL_W+1)'(tap_dc(t));
      mask[t] = !rr[ROW_W] && (rr <= ROW_MAX) && !cc[COL_W] && (cc <= COL_MAX);
    end
  end

endmodule

// File: rtl/window_ctrl.sv
// Window scan / zero-padding control between memory and the arithmetic part.
// Optional WINDOW_CTRL_STRIDE2_EN adds a stride2 input (even rows/cols only).
module window_ctrl
  import npu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIAS_W  = 16,
  parameter int NCH     = 8,
  parameter int IMG_W   = 80,
  parameter int IMG_H   = 8,
  parameter int COL_W   = 7,
  parameter int ROW_W   = 3,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    en_bias,
`ifdef WINDOW_CTRL_STRIDE2_EN
  input  logic                    stride2,
`endif
  output logic                    rd_valid,
  output logic [ROW_W-1:0]        rd_row,
  output logic [COL_W-1:0]        rd_col,
  input  logic [TAPS*DATA_W-1:0]  fmaps,
  input  logic [NCH*BIAS_W-1:0]   biases,
  output logic [TAPS*DATA_W-1:0]  fmap,
  output logic [NCH*BIAS_W-1:0]   biasp,
  output logic                    fmap_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [COL_W:0] COL_LAST = (COL_W+1)'(IMG_W - 1);
  localparam logic [ROW_W:0] ROW_LAST = (ROW_W+1)'(IMG_H - 1);

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  mask_t              mask_now;
  mask_t              iss_mask;
  logic               iss_bias;
  logic [MEM_LAT-1:0] dly_valid;
  logic [MEM_LAT-1:0] dly_bias;
  mask_t              dly_mask [MEM_LAT];
  logic [MEM_LAT-1:0] early;
  logic               pending;
  logic [1:0]         step;
  logic [COL_W:0]     col_step;
  logic [ROW_W:0]     row_step;
  logic               col_wrap;
  logic               row_last;

`ifdef WINDOW_CTRL_STRIDE2_EN
  logic step2;
  assign step = step2 ? 2'd2 : 2'd1;
`else
  assign step = 2'd1;
`endif

  assign col_step = {1'b0, col} + (COL_W+1)'(step);
  assign row_step = {1'b0, row} + (ROW_W+1)'(step);
  assign col_wrap = col_step > COL_LAST;
  assign row_last = row_step > ROW_LAST;

  pad_mask_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_mask (
    .row  (row),
    .col  (col),
    .mask (mask_now)
  );

  // Anything still in flight other than the beat currently at the output.
  always_comb begin
    early = dly_valid;
    early[MEM_LAT-1] = 1'b0;
  end
  assign pending = rd_valid | (|early);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      rd_valid  <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
      iss_mask  <= '0;
      iss_bias  <= 1'b0;
      dly_valid <= '0;
      dly_bias  <= '0;
      for (int i = 0; i < MEM_LAT; i++) dly_mask[i] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef WINDOW_CTRL_STRIDE2_EN
      step2     <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      iss_mask <= '0;
      iss_bias <= 1'b0;
      done     <= 1'b0;

      dly_valid[0] <= rd_valid;
      dly_bias[0]  <= iss_bias;
      dly_mask[0]  <= iss_mask;
      for (int i = 1; i < MEM_LAT; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_bias[i]  <= dly_bias[i-1];
        dly_mask[i]  <= dly_mask[i-1];
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
`ifdef WINDOW_CTRL_STRIDE2_EN
            step2 <= stride2;
`endif
          end
        end
        ST_RUN: begin
          if (!pause) begin
            rd_valid <= 1'b1;
            rd_row   <= row;
            rd_col   <= col;
            iss_mask <= mask_now;
            iss_bias <= en_bias;
            if (col_wrap) begin
              col <= '0;
              if (row_last) state <= ST_DRAIN;
              else          row   <= row_step[ROW_W-1:0];
            end else begin
              col <= col_step[COL_W-1:0];
            end
          end
        end
        ST_DRAIN: begin
          if (!pending) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fmap_valid = dly_valid[MEM_LAT-1];

  // The delayed mask is zero on non-valid cycles, so fmap is zero then too.
  for (genvar t = 0; t < TAPS; t++) begin : g_lane
    assign fmap[t*DATA_W +: DATA_W] =
      dly_mask[MEM_LAT-1][t] ? fmaps[t*DATA_W +: DATA_W] : '0;
  end

  assign biasp = (dly_valid[MEM_LAT-1] && dly_bias[MEM_LAT-1]) ? biases : '0;

endmodule

// File: tb/tb_window_ctrl.sv
// Randomized scoreboard bench for window_ctrl on a 4x3 map with MEM_LAT=1;
// exercises stride-2 frames too when WINDOW_CTRL_STRIDE2_EN is defined.
module tb_window_ctrl;

  localparam int DATA_W  = 8;
  localparam int BIAS_W  = 16;
  localparam int NCH     = 8;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 3;
  localparam int COL_W   = 2;
  localparam int ROW_W   = 2;
  localparam int MEM_LAT = 1;
  localparam int FW      = 9 * DATA_W;
  localparam int BW      = NCH * BIAS_W;

  logic             clk = 1'b0;
  logic             rst, start, pause, en_bias, stride2;
  logic             rd_valid, fmap_valid, busy, done;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [FW-1:0]    fmaps, fmap;
  logic [BW-1:0]    biases, biasp;

  typedef struct { int r; int c; } ctr_t;
  typedef struct { logic [8:0] m; bit b; int due; } beat_t;

  ctr_t  exp_iss[$];
  beat_t exp_beat[$];
  int    total = 0, bad = 0;
  int    cyc = 0, done_due = -1, done_cnt = 0, issued = 0;
  bit    frame_open = 0;

  always #5 clk = ~clk;

  window_ctrl #(
    .DATA_W(DATA_W), .BIAS_W(BIAS_W), .NCH(NCH), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .COL_W(COL_W), .ROW_W(ROW_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .en_bias(en_bias),
`ifdef WINDOW_CTRL_STRIDE2_EN
    .stride2(stride2),
`endif
    .rd_valid(rd_valid), .rd_row(rd_row), .rd_col(rd_col),
    .fmaps(fmaps), .biases(biases), .fmap(fmap), .biasp(biasp),
    .fmap_valid(fmap_valid), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Tap in-image test straight from the window geometry.
  function automatic logic [8:0] ref_mask(input int r, input int c);
    logic [8:0] m;
    m = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < IMG_H && c + dc >= 0 && c + dc < IMG_W)
          m[8 - ((dr + 1) * 3 + (dc + 1))] = 1'b1;
    return m;
  endfunction

  function automatic logic [FW-1:0] ref_fmap(input logic [8:0] m, input logic [FW-1:0] f);
    logic [FW-1:0] o;
    o = '0;
    for (int t = 0; t < 9; t++)
      if (m[t]) o[t*DATA_W +: DATA_W] = f[t*DATA_W +: DATA_W];
    return o;
  endfunction

  // Monitor: samples mid-cycle, inputs change 1 time unit after the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_outputs",
          128'({rd_valid, rd_row, rd_col, fmap_valid, busy, done, |fmap, |biasp}), 128'(0));
      exp_iss.delete();
      exp_beat.delete();
      done_due   = -1;
      frame_open = 0;
    end else begin
      if (pause) chk("issue_while_paused", 128'(rd_valid), 128'(0));
      if (rd_valid) begin
        issued++;
        chk("busy_at_issue", 128'(busy), 128'(1));
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", 128'(rd_valid), 128'(0));
        end else begin
          ctr_t e;
          beat_t b;
          e = exp_iss.pop_front();
          chk("rd_row", 128'(rd_row), 128'(e.r));
          chk("rd_col", 128'(rd_col), 128'(e.c));
          b.m = ref_mask(e.r, e.c);
          b.b = en_bias;
          b.due = cyc + MEM_LAT;
          exp_beat.push_back(b);
        end
      end
      if (fmap_valid) begin
        if (exp_beat.size() == 0) begin
          chk("unexpected_beat", 128'(fmap_valid), 128'(0));
        end else begin
          beat_t b;
          b = exp_beat.pop_front();
          chk("beat_latency", 128'(cyc), 128'(b.due));
          chk("fmap", 128'(fmap), 128'(ref_fmap(b.m, fmaps)));
          chk("biasp", 128'(biasp), b.b ? 128'(biases) : 128'(0));
          if (frame_open && exp_iss.size() == 0 && exp_beat.size() == 0)
            done_due = cyc + 1;
        end
      end else begin
        chk("idle_zero", 128'({fmap, biasp}), 128'(0));
      end
      chk("done", 128'(done), 128'(cyc == done_due));
      if (done) begin
        done_cnt++;
        frame_open = 0;
        chk("busy_at_done", 128'(busy), 128'(0));
      end
    end
  end

  task automatic drive_data(input int bmode);
    for (int t = 0; t < 9; t++) fmaps[t*DATA_W +: DATA_W] = DATA_W'($urandom);
    for (int n = 0; n < NCH; n++)
      biases[n*BIAS_W +: BIAS_W] = (bmode == 1) ? 16'hAAAA : BIAS_W'($urandom);
  endtask

  // pmode: 0 none, 1 three-cycle pause after 5th issue, 2 random pause/start.
  // bmode: 0 random en_bias, 1 en_bias on 2nd issue only. rst_at>0: reset then.
  task automatic run_frame(input bit s2, input int pmode, input int bmode, input int rst_at);
    int  step, d0, pcnt, budget;
    bit  ended;
    step = s2 ? 2 : 1;
    for (int r = 0; r < IMG_H; r += step)
      for (int c = 0; c < IMG_W; c += step) exp_iss.push_back('{r, c});
    frame_open = 1;
    issued     = 0;
    d0         = done_cnt;
    pcnt       = 0;
    budget     = 0;
    ended      = 0;
    stride2    = s2;
    start      = 1'b1;
    drive_data(bmode);
    while (!ended && budget < 400) begin
      @(negedge clk);
      #1;
      budget++;
      start = (pmode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      drive_data(bmode);
      if (done_cnt != d0) begin
        ended = 1;
      end else if (rst) begin
        rst   = 1'b0;
        ended = 1;
      end else if (rst_at > 0 && issued == rst_at) begin
        rst = 1'b1;
      end
      if (pmode == 1) begin
        pause = (issued == 5 && pcnt < 3);
        if (pause) pcnt++;
      end else if (pmode == 2) begin
        pause = ($urandom_range(0, 3) == 0);
      end else begin
        pause = 1'b0;
      end
      en_bias = (bmode == 1) ? (issued == 1) : 1'($urandom_range(0, 1));
    end
    chk("frame_end_reached", 128'(ended), 128'(1));
    start   = 1'b0;
    pause   = 1'b0;
    en_bias = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; en_bias = 1'b0; stride2 = 1'b0;
    fmaps = '0; biases = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    run_frame(1'b0, 0, 0, 0);
    run_frame(1'b0, 1, 1, 0);
    run_frame(1'b0, 0, 0, 7);
    run_frame(1'b0, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_frame(1'b0, 2, 0, 0);
`ifdef WINDOW_CTRL_STRIDE2_EN
    run_frame(1'b1, 0, 0, 0);
    run_frame(1'b1, 2, 0, 0);
    run_frame(1'b0, 2, 0, 0);
`endif
    chk("frames_completed", 128'(done_cnt), 128'(
`ifdef WINDOW_CTRL_STRIDE2_EN
        9
`else
        6
`endif
    ));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_ctrl.md
Name: window_ctrl

Overview:
- Parametrised successor to the zero-padding control stage between the Memory part and the Arithmetic part.
- Scans a KxK (K=3, 9-tap) window centre across an IMG_W x IMG_H feature map, SAME padding, stride 1.
- Issues read coordinates to memory and generates the per-tap read-enable mask internally rather than taking it as an input.
- Delays mask, valid and bias enable by MEM_LAT cycles so they align with memory data, then zero-pads out-of-image taps before the Arithmetic part.

Parameters:
- DATA_W, 8, bits per fmap tap
- BIAS_W, 16, bits per bias lane
- NCH, 8, bias lanes
- IMG_W, 80, fmap width in pixels
- IMG_H, 8, fmap height in pixels
- COL_W, 7, column counter width, ceil(log2(IMG_W))
- ROW_W, 3, row counter width, ceil(log2(IMG_H))
- MEM_LAT, 1, memory read latency in cycles, >=1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle frame start pulse
- pause  in  1  suppresses new read issues; in-flight reads still complete
- en_bias  in  1  bias request, sampled on issue cycles
- rd_valid  out  1  read issue strobe
- rd_row  out  ROW_W  window-centre row of the issued read
- rd_col  out  COL_W  window-centre column of the issued read
- fmaps  in  9*DATA_W  tap data from memory, MEM_LAT cycles after the issue; lane 8 in the MSBs
- biases  in  NCH*BIAS_W  bias data from memory
- fmap  out  9*DATA_W  zero-padded taps to the Arithmetic part
- biasp  out  NCH*BIAS_W  gated biases
- fmap_valid  out  1  fmap/biasp qualifier
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, pipeline cleared. Reset mid-frame aborts immediately; no done is produced.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. Clear row=0, col=0.
  - start while busy is ignored.
- RUN issue cycle (when pause=0):
  - Registered outputs: rd_valid=1, rd_row=row, rd_col=col.
  - The mask and the sampled en_bias enter the delay pipeline.
  - col increments. At col=IMG_W-1 it wraps to 0 and row increments.
- RUN with pause=1: rd_valid=0, counters hold, a bubble enters the pipeline.
- RUN -> DRAIN after issuing (IMG_H-1, IMG_W-1).
- DRAIN lasts until the pipeline is empty. done pulses in the cycle after the last fmap_valid, then the FSM returns to IDLE. pause is ignored in DRAIN.
- Tap index t = 8 - ((dr+1)*3 + (dc+1)) for dr, dc in {-1,0,+1}. Bit 8 is top-left (-1,-1); bit 0 is bottom-right (+1,+1).
- Mask bit t = 1 iff 0 <= row+dr <= IMG_H-1 and 0 <= col+dc <= IMG_W-1. Compute in signed arithmetic one bit wider than the counters; no wrap-around aliasing.
- Pipeline: mask, valid and en_bias each delayed MEM_LAT cycles from the rd_valid cycle. fmap_valid is high exactly MEM_LAT cycles after rd_valid.
- fmap lane t = delayed_mask[t] ? fmaps lane t : 0. This is combinational from fmaps and the registered delayed mask.
- biasp = (delayed_valid & delayed_en_bias) ? biases : 0.
- When fmap_valid=0, fmap is all zeros.
- Total frame: IMG_W*IMG_H issues and the same number of fmap_valid beats.

Optional Feature:
- Macro: WINDOW_CTRL_STRIDE2_EN.
- Defined: adds input port stride2 (1 bit), sampled at start and held for the frame. When set, centres visit only even rows and even columns. Each step is +2, the wrap occurs when col+2 > IMG_W-1, and the last issue is the largest even row/column. Frame length is ceil(IMG_W/2)*ceil(IMG_H/2). The mask rule is unchanged.
- Undefined: no stride2 port; stride fixed at 1.

Decomposition:
- Package npu_ctrl_pkg:
  - FSM state enum
  - tap-count constant TAPS=9
  - tap-offset lookup (dr, dc per tap index)
  - mask-width typedef
- Sub-module pad_mask_gen: pure combinational. Takes row and col, returns the 9-bit mask. It is reusable by future kernel-size variants.

Test Plan (IMG_W=4, IMG_H=3, MEM_LAT=1, WINDOW_CTRL_STRIDE2_EN undefined unless noted):
1. Reset then start: first rd_valid at (0,0), internal mask 0x01B. Next cycle fmap_valid=1, with lanes 8,7,6,5,2 = 0 and lanes 4,3,1,0 = fmaps.
2. Full frame, no pause: 12 consecutive rd_valid; centre (1,1) mask 0x1FF; last (2,3) mask 0x1B0. done pulses exactly once, 2 cycles after the last rd_valid. busy then drops to 0.
3. Assert pause for 3 cycles after the 5th issue: rd_valid gaps of 3, counters hold at (1,1), still 12 beats total. The 5th beat's fmap_valid arrives despite pause.
4. en_bias=1 only on the 2nd issue, biases=0xAAAA…: biasp non-zero only on the 2nd fmap_valid beat.
5. rst asserted mid-frame at the 7th issue: next cycle all outputs 0 and state IDLE. A new start replays from (0,0).
6. WINDOW_CTRL_STRIDE2_EN defined, stride2=1: issues at (0,0),(0,2),(2,0),(2,2) only; 4 beats, then done.
